operand_load_scheduler: RTL and testbench
=========================================

Name: operand_load_scheduler

Overview:
Sequencer between the switch inputs and the 4-operand nibble compute block. It captures operand write strobes with synchronisation and edge detection, and serialises them through one shared operand write port using a round-robin arbiter. It freezes the operands while the compute block evaluates, then captures the block result. It replaces the free-running per-cycle operand loads in the top level.

Parameters:
DATA_W, 4, operand and result width
NUM_OPS, 4, number of operand slots (in1..in4)
SYNC_STAGES, 2, synchroniser depth for sel_in and data_in (min 2)
EVAL_CYCLES, 3, cycles operands are held stable before block_out is captured (min 1)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
data_in  input  DATA_W  raw operand value from switches
sel_in  input  NUM_OPS  raw per-slot write strobes; bit i targets slot i
run_req  input  1  synchronous pulse; request an evaluation
auto_run  input  1  level; start evaluation automatically when all slots are loaded
err_clr  input  1  synchronous pulse; clears overrun
block_out  input  DATA_W  combinational result from the compute block
op_out  output  NUM_OPS*DATA_W  operand registers; slot i at bits [i*DATA_W +: DATA_W]
loaded_mask  output  NUM_OPS  slot i written since the last evaluation
busy  output  1  high in EVAL and DONE
result  output  DATA_W  captured block_out
result_valid  output  1  result holds a completed evaluation
overrun  output  1  sticky; a new strobe edge arrived on a slot that was still pending

Behaviour:
- Reset: every flop clears asynchronously. This gives op_out=0, loaded_mask=0, busy=0, result=0, result_valid=0, overrun=0, pending=0, RR pointer=0, state IDLE.
- Synchronisation: sel_in and data_in each pass through SYNC_STAGES flops.
- Edge detect: a rising edge on synced sel bit i sets pending[i] and writes the synced data into stage[i].
- Latency: sel_in[i] rises, data held stable, uncontended, state IDLE, first sampled at edge k. Then pending[i] is set at edge k+SYNC_STAGES+1 and op_out slot i is updated at edge k+SYNC_STAGES+2.
- Overrun: an edge on slot i while pending[i]=1 overwrites stage[i] (last value wins) and sets overrun.
- overrun clears only on err_clr. If err_clr and a new overrun occur in the same cycle, overrun stays set.
- Arbiter: one commit per cycle, allowed in IDLE only. It grants the first pending slot searching from the RR pointer upward, mod NUM_OPS.
- On a grant to slot i: op slot i <= stage[i], pending[i] cleared, loaded_mask[i] set, pointer <= (i+1) mod NUM_OPS.
- An edge on slot i in the same cycle as its grant: the old stage value commits, and pending[i] stays set with the new data. This does not count as overrun.
- FSM IDLE:
  - Goes to EVAL on run_req, or when auto_run=1, loaded_mask all ones and pending=0.
  - On that transition: load counter with EVAL_CYCLES-1 and clear result_valid.
  - run_req wins over a commit in the same cycle; no commit happens that cycle.
- FSM EVAL:
  - op_out is frozen and no commits occur; edges still set pending and stage.
  - The counter decrements each cycle.
  - At counter 0: result <= block_out, result_valid <= 1, loaded_mask <= 0, go to DONE.
  - EVAL therefore lasts exactly EVAL_CYCLES cycles.
- FSM DONE: one cycle, no commits, then IDLE.
- busy=1 in EVAL and DONE. run_req while busy is ignored, not queued.
- auto_run fires at most once per full load, because loaded_mask is cleared at capture.
- result_valid stays high until the next EVAL entry.
- Simultaneous edges on several slots in one cycle all capture the same synced data and commit over successive cycles in RR order.

Decomposition:
- Shared package operand_sched_pkg holds:
  - state enum (IDLE, EVAL, DONE)
  - default DATA_W and NUM_OPS constants
  - the slot-index width function (clog2 of NUM_OPS)
- One natural sub-module: rr_arbiter. It takes the request vector and pointer, and returns the one-hot grant and encoded index. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset mid-EVAL: assert rst_n low during the EVAL counter -> all outputs 0 immediately (asynchronous), and after release the state is IDLE with pointer 0.
- Single load: data_in=4'hA, sel_in=4'b0001 held 4 cycles -> op_out[3:0]=A at edge k+4 (SYNC_STAGES=2), loaded_mask=0001, other slots 0.
- Contention: data_in=4'h5, sel_in 0000->1111 in one cycle -> slots commit in order 0,1,2,3 on consecutive cycles, all equal 5, pointer ends at 0. Repeat with pointer at 2 -> order 2,3,0,1.
- Auto run: auto_run=1, load 1,2,3,4 into slots 0..3, block_out driven to 4'hC -> busy for exactly 4 cycles (EVAL 3 + DONE 1), result=C, result_valid=1, loaded_mask=0000, no second evaluation.
- Freeze: edge on slot 1 with value 9 during EVAL -> op_out unchanged until DONE exits, then slot 1=9 committed on the first IDLE cycle.
- Overrun: two edges on slot 2 (values 3 then 7) while pending is held by EVAL -> overrun=1 and slot 2 commits 7. err_clr pulse -> overrun=0.

Source files
------------

// File: rtl/operand_load_scheduler_pkg.sv
// Shared definitions for the operand load scheduler.
//   sched_state_t   : scheduler FSM states (IDLE, EVAL, DONE)
//   DEFAULT_DATA_W  : default operand/result width
//   DEFAULT_NUM_OPS : default number of operand slots
//   idx_width()     : bits needed to index n items (never less than 1)
package operand_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    localparam int DEFAULT_DATA_W  = 4;
    localparam int DEFAULT_NUM_OPS = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_load_scheduler_rr_arbiter.sv
// Round-robin arbiter for the shared operand write port (combinational).
// The pointer register lives in the parent; this block only searches.
//   req   : request vector, one bit per operand slot
//   ptr   : slot index where the search starts
//   grant : one-hot grant (all zero when nothing requests)
//   idx   : encoded index of the granted slot
//   found : at least one request present
module rr_arbiter
    import operand_sched_pkg::*;
#(
    parameter int NUM_OPS = DEFAULT_NUM_OPS,
    parameter int IDX_W   = idx_width(NUM_OPS)
) (
    input  logic [NUM_OPS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_OPS-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    // Search upward from ptr, wrapping mod NUM_OPS; first requester wins.
    always_comb begin : search
        int slot;
        slot  = 0;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_OPS; off++) begin
            slot = (int'(ptr) + off) % NUM_OPS;
            if (!found && req[slot]) begin
                found       = 1'b1;
                grant[slot] = 1'b1;
                idx         = IDX_W'(slot);
            end
        end
    end

endmodule

// File: rtl/operand_load_scheduler.sv
// Operand load scheduler: synchronises switch strobes, detects rising edges,
// serialises operand writes through one round-robin write port, freezes the
// operands while the compute block evaluates and captures its result.
//   clk, rst_n   : clock, asynchronous active-low reset
//   data_in      : raw operand value from switches
//   sel_in       : raw per-slot write strobes (bit i -> slot i)
//   run_req      : pulse, request an evaluation (ignored while busy)
//   auto_run     : level, evaluate once all slots are loaded and nothing pends
//   err_clr      : pulse, clears the sticky overrun flag
//   block_out    : combinational result of the compute block
//   op_out       : operand registers, slot i at [i*DATA_W +: DATA_W]
//   loaded_mask  : slots written since the last evaluation
//   busy         : high in EVAL and DONE
//   result       : captured block_out
//   result_valid : result holds a completed evaluation
//   overrun      : sticky, a strobe edge hit a slot that was still pending
//
// Handshake: sel_in edges are fire-and-forget; a slot stays pending until the
// arbiter commits it in IDLE. run_req is a single-cycle request, honoured only
// in IDLE and never queued.
module operand_load_scheduler
    import operand_sched_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int NUM_OPS     = DEFAULT_NUM_OPS,
    parameter int SYNC_STAGES = 2,
    parameter int EVAL_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [NUM_OPS-1:0]        sel_in,
    input  logic                      run_req,
    input  logic                      auto_run,
    input  logic                      err_clr,
    input  logic [DATA_W-1:0]         block_out,
    output logic [NUM_OPS*DATA_W-1:0] op_out,
    output logic [NUM_OPS-1:0]        loaded_mask,
    output logic                      busy,
    output logic [DATA_W-1:0]         result,
    output logic                      result_valid,
    output logic                      overrun
);

    localparam int IDX_W = idx_width(NUM_OPS);
    localparam int CNT_W = idx_width(EVAL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EVAL_CYCLES - 1);

    // Input synchronisers and registered edge detect
    logic [NUM_OPS-1:0] sel_sync  [SYNC_STAGES];
    logic [DATA_W-1:0]  data_sync [SYNC_STAGES];
    logic [NUM_OPS-1:0] sel_last;
    logic [NUM_OPS-1:0] edge_q;
    logic [DATA_W-1:0]  data_q;

    // Per-slot staging and scheduling state
    logic [DATA_W-1:0]         stage [NUM_OPS];
    logic [NUM_OPS-1:0]        pending;
    logic [IDX_W-1:0]          ptr;
    logic [NUM_OPS*DATA_W-1:0] op_q;
    logic [NUM_OPS-1:0]        loaded_q;
    logic [DATA_W-1:0]         result_q;
    logic                      result_valid_q;
    logic                      overrun_q;

    // FSM
    sched_state_t     state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             start_eval;
    logic             capture;
    logic             auto_go;

    // Arbiter
    logic [NUM_OPS-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic               commit;
    logic [NUM_OPS-1:0] commit_mask;
    logic [NUM_OPS-1:0] ovr_hit;
    logic [IDX_W-1:0]   ptr_after;

    // The edge is registered once more after the synchroniser so the data
    // word (data_q) lines up with the edge that captures it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sel_sync[s]  <= '0;
                data_sync[s] <= '0;
            end
            sel_last <= '0;
            edge_q   <= '0;
            data_q   <= '0;
        end else begin
            sel_sync[0]  <= sel_in;
            data_sync[0] <= data_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sel_sync[s]  <= sel_sync[s-1];
                data_sync[s] <= data_sync[s-1];
            end
            sel_last <= sel_sync[SYNC_STAGES-1];
            edge_q   <= sel_sync[SYNC_STAGES-1] & ~sel_last;
            data_q   <= data_sync[SYNC_STAGES-1];
        end
    end

    rr_arbiter #(
        .NUM_OPS (NUM_OPS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (pending),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (grant_found)
    );

    // Auto start needs every slot loaded and nothing still in flight.
    assign auto_go = auto_run && (&loaded_q) && !(|pending);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start_eval = 1'b0;
        capture    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (run_req || auto_go) begin
                    state_next = ST_EVAL;
                    cnt_next   = CNT_LOAD;
                    start_eval = 1'b1;
                end
            end
            ST_EVAL: begin
                if (cnt == '0) begin
                    state_next = ST_DONE;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Commits only in IDLE; a starting evaluation takes priority.
    assign commit      = (state == ST_IDLE) && !start_eval && grant_found;
    assign commit_mask = commit ? grant : '0;
    // A slot being granted this cycle frees its stage, so a fresh edge
    // there is a normal reload rather than an overrun.
    assign ovr_hit     = edge_q & pending & ~commit_mask;
    assign ptr_after   = IDX_W'((int'(grant_idx) + 1) % NUM_OPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                stage[i] <= '0;
            end
            pending        <= '0;
            ptr            <= '0;
            op_q           <= '0;
            loaded_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            // Commit reads the old stage value; a same-cycle edge replaces it.
            for (int i = 0; i < NUM_OPS; i++) begin
                if (edge_q[i]) begin
                    stage[i] <= data_q;
                end
            end
            pending   <= (pending & ~commit_mask) | edge_q;
            overrun_q <= (overrun_q & ~err_clr) | (|ovr_hit);

            if (commit) begin
                op_q[grant_idx*DATA_W +: DATA_W] <= stage[grant_idx];
                ptr                              <= ptr_after;
            end

            if (capture) begin
                loaded_q <= '0;
            end else begin
                loaded_q <= loaded_q | commit_mask;
            end

            if (start_eval) begin
                result_valid_q <= 1'b0;
            end else if (capture) begin
                result_valid_q <= 1'b1;
            end

            if (capture) begin
                result_q <= block_out;
            end
        end
    end

    assign op_out       = op_q;
    assign loaded_mask  = loaded_q;
    assign busy         = (state != ST_IDLE);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_operand_load_scheduler.sv
// Testbench for operand_load_scheduler: directed table of single loads,
// hand-written multi-cycle sequences and a randomized run, all compared
// against constants or a behavioural model of the scheduling rules.
module tb_operand_load_scheduler;

    localparam int DATA_W      = 4;
    localparam int NUM_OPS     = 4;
    localparam int SYNC_STAGES = 2;
    localparam int EVAL_CYCLES = 3;
    localparam int OPS_W       = NUM_OPS * DATA_W;

    localparam int PH_IDLE = 0;
    localparam int PH_EVAL = 1;
    localparam int PH_DONE = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0]  data_in   = '0;
    logic [NUM_OPS-1:0] sel_in    = '0;
    logic               run_req   = 1'b0;
    logic               auto_run  = 1'b0;
    logic               err_clr   = 1'b0;
    logic [DATA_W-1:0]  block_out = '0;

    logic [OPS_W-1:0]   op_out;
    logic [NUM_OPS-1:0] loaded_mask;
    logic               busy;
    logic [DATA_W-1:0]  result;
    logic               result_valid;
    logic               overrun;

    int n_checks = 0;
    int n_fail   = 0;

    operand_load_scheduler #(
        .DATA_W      (DATA_W),
        .NUM_OPS     (NUM_OPS),
        .SYNC_STAGES (SYNC_STAGES),
        .EVAL_CYCLES (EVAL_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .sel_in       (sel_in),
        .run_req      (run_req),
        .auto_run     (auto_run),
        .err_clr      (err_clr),
        .block_out    (block_out),
        .op_out       (op_out),
        .loaded_mask  (loaded_mask),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

    // ---------------- reference model ----------------
    // The model works from input history: a strobe edge seen at sample t
    // becomes pending SYNC_STAGES+1 edges later.
    typedef struct {
        logic [NUM_OPS-1:0] sel;
        logic [DATA_W-1:0]  data;
    } sample_t;

    sample_t hist[$];
    int m_op    [NUM_OPS];
    int m_stage [NUM_OPS];
    bit m_pend  [NUM_OPS];
    bit m_mask  [NUM_OPS];
    int m_ptr, m_phase, m_left, m_result;
    bit m_rv, m_ov;

    task automatic model_reset();
        sample_t z;
        z.sel  = '0;
        z.data = '0;
        hist.delete();
        for (int i = 0; i < SYNC_STAGES + 3; i++) hist.push_back(z);
        for (int i = 0; i < NUM_OPS; i++) begin
            m_op[i]    = 0;
            m_stage[i] = 0;
            m_pend[i]  = 1'b0;
            m_mask[i]  = 1'b0;
        end
        m_ptr    = 0;
        m_phase  = PH_IDLE;
        m_left   = 0;
        m_result = 0;
        m_rv     = 1'b0;
        m_ov     = 1'b0;
    endtask

    task automatic model_step();
        sample_t cur, older, newer;
        int  granted;
        bit  any_pend, all_loaded, go, new_ov;
        cur.sel  = sel_in;
        cur.data = data_in;
        hist.push_back(cur);
        void'(hist.pop_front());
        older = hist[0];
        newer = hist[1];
        granted    = -1;
        any_pend   = 1'b0;
        all_loaded = 1'b1;
        for (int i = 0; i < NUM_OPS; i++) begin
            any_pend   = any_pend | m_pend[i];
            all_loaded = all_loaded & m_mask[i];
        end
        case (m_phase)
            PH_IDLE: begin
                go = run_req || (auto_run && all_loaded && !any_pend);
                if (go) begin
                    m_phase = PH_EVAL;
                    m_left  = EVAL_CYCLES;
                    m_rv    = 1'b0;
                end else begin
                    for (int off = 0; off < NUM_OPS && granted < 0; off++) begin
                        int s;
                        s = (m_ptr + off) % NUM_OPS;
                        if (m_pend[s]) granted = s;
                    end
                    if (granted >= 0) begin
                        m_op[granted]   = m_stage[granted];
                        m_mask[granted] = 1'b1;
                        m_pend[granted] = 1'b0;
                        m_ptr           = (granted + 1) % NUM_OPS;
                    end
                end
            end
            PH_EVAL: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_result = int'(block_out);
                    m_rv     = 1'b1;
                    for (int i = 0; i < NUM_OPS; i++) m_mask[i] = 1'b0;
                    m_phase = PH_DONE;
                end
            end
            default: m_phase = PH_IDLE;
        endcase
        new_ov = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (newer.sel[i] && !older.sel[i]) begin
                if (m_pend[i]) new_ov = 1'b1;
                m_pend[i]  = 1'b1;
                m_stage[i] = int'(newer.data);
            end
        end
        if (new_ov) m_ov = 1'b1;
        else if (err_clr) m_ov = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [OPS_W-1:0]   exp_op;
        logic [NUM_OPS-1:0] exp_mask;
        exp_op   = '0;
        exp_mask = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            exp_op[i*DATA_W +: DATA_W] = DATA_W'(m_op[i]);
            exp_mask[i]                = m_mask[i];
        end
        chk("model op_out", 32'(op_out), 32'(exp_op));
        chk("model loaded_mask", 32'(loaded_mask), 32'(exp_mask));
        chk("model busy", 32'(busy), 32'(m_phase != PH_IDLE));
        chk("model result", 32'(result), 32'(m_result));
        chk("model result_valid", 32'(result_valid), 32'(m_rv));
        chk("model overrun", 32'(overrun), 32'(m_ov));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset op_out", 32'(op_out), 32'h0);
        chk("reset loaded_mask", 32'(loaded_mask), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset result", 32'(result), 32'h0);
        chk("reset result_valid", 32'(result_valid), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Strobe one slot for 4 cycles; commit lands 4 edges after first sample.
    task automatic single_load(input int slot, input logic [DATA_W-1:0] val,
                               inout logic [OPS_W-1:0] exp_op);
        data_in = val;
        for (int j = 1; j <= 6; j++) begin
            sel_in = (j <= 4) ? (NUM_OPS'(1) << slot) : '0;
            cycle();
            if (j == 5) exp_op[slot*DATA_W +: DATA_W] = val;
            chk("load op_out", 32'(op_out), 32'(exp_op));
        end
    endtask

    // All strobes rise together; commits follow round-robin from first_slot.
    task automatic contention(input logic [DATA_W-1:0] val, input int first_slot,
                              inout logic [OPS_W-1:0] exp_op);
        data_in = val;
        for (int j = 1; j <= 9; j++) begin
            sel_in = (j <= 4) ? '1 : '0;
            cycle();
            if (j >= 5 && j <= 8)
                exp_op[((first_slot + j - 5) % NUM_OPS)*DATA_W +: DATA_W] = val;
            chk("contention op_out", 32'(op_out), 32'(exp_op));
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int                 slot;
        logic [DATA_W-1:0]  val;
        logic [OPS_W-1:0]   exp_op;
        logic [NUM_OPS-1:0] exp_mask;
    } load_vec_t;

    load_vec_t vecs[4];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [OPS_W-1:0] cur_op;
        logic [OPS_W-1:0] prev_op;
        int busy_cnt;

        vecs[0] = '{0, 4'hA, 16'h000A, 4'b0001};
        vecs[1] = '{2, 4'h3, 16'h030A, 4'b0101};
        vecs[2] = '{1, 4'hF, 16'h03FA, 4'b0111};
        vecs[3] = '{0, 4'h6, 16'h03F6, 4'b0111};

        model_reset();
        do_reset();
        cycle();

        // Table of single uncontended loads
        prev_op = '0;
        for (int v = 0; v < 4; v++) begin
            data_in = vecs[v].val;
            for (int j = 1; j <= 6; j++) begin
                sel_in = (j <= 4) ? (NUM_OPS'(1) << vecs[v].slot) : '0;
                cycle();
                if (j == 4) chk("table op_out before commit", 32'(op_out), 32'(prev_op));
                if (j == 5) begin
                    chk("table op_out", 32'(op_out), 32'(vecs[v].exp_op));
                    chk("table loaded_mask", 32'(loaded_mask), 32'(vecs[v].exp_mask));
                end
            end
            prev_op = vecs[v].exp_op;
        end

        // Auto run: load 1,2,3,4 then expect exactly one 4-cycle busy window
        cur_op    = prev_op;
        block_out = 4'hC;
        auto_run  = 1'b1;
        single_load(0, 4'h1, cur_op);
        single_load(1, 4'h2, cur_op);
        single_load(2, 4'h3, cur_op);
        data_in  = 4'h4;
        busy_cnt = 0;
        for (int j = 1; j <= 20; j++) begin
            sel_in = (j <= 4) ? 4'b1000 : 4'b0000;
            cycle();
            if (busy) busy_cnt++;
        end
        auto_run = 1'b0;
        cur_op   = 16'h4321;
        chk("auto busy cycles", 32'(busy_cnt), 32'd4);
        chk("auto result", 32'(result), 32'hC);
        chk("auto result_valid", 32'(result_valid), 32'h1);
        chk("auto loaded_mask", 32'(loaded_mask), 32'h0);
        chk("auto op_out", 32'(op_out), 32'(cur_op));

        // Freeze: slot 1 strobed with 9 as evaluation starts
        data_in = 4'h9;
        sel_in  = 4'b0010;
        run_req = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cycle();
            run_req = 1'b0;
            if (j == 2) sel_in = 4'b0000;
            if (j <= 4) chk("freeze busy", 32'(busy), 32'h1);
            if (j == 5) chk("freeze busy after DONE", 32'(busy), 32'h0);
            if (j == 6) cur_op = 16'h4391;
            chk("freeze op_out", 32'(op_out), 32'(cur_op));
        end

        // Overrun: slot 2 gets 3 then 7 while EVAL holds it pending
        data_in = 4'h3;
        sel_in  = 4'b0100;
        cycle();
        sel_in = 4'b0000;
        cycle();
        data_in = 4'h7;
        sel_in  = 4'b0100;
        run_req = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cycle();
            run_req = 1'b0;
            sel_in  = 4'b0000;
            if (j == 4) chk("overrun set", 32'(overrun), 32'h1);
        end
        cur_op = 16'h4791;
        chk("overrun last value wins", 32'(op_out), 32'(cur_op));
        chk("overrun sticky", 32'(overrun), 32'h1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("overrun cleared", 32'(overrun), 32'h0);
        cycle();

        // Reset in the middle of EVAL
        run_req = 1'b1;
        cycle();
        run_req = 1'b0;
        cycle();
        chk("mid-eval busy before reset", 32'(busy), 32'h1);
        do_reset();
        cycle();
        cur_op = '0;

        // Contention from pointer 0, then from pointer 2
        contention(4'h5, 0, cur_op);
        chk("contention A result", 32'(op_out), 32'h5555);
        single_load(1, 4'h8, cur_op);
        contention(4'h6, 2, cur_op);
        chk("contention B result", 32'(op_out), 32'h6666);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_OPS; i++)
                if ($urandom_range(5, 0) == 0) sel_in[i] = ~sel_in[i];
            data_in   = DATA_W'($urandom_range(15, 0));
            block_out = DATA_W'($urandom_range(15, 0));
            run_req   = ($urandom_range(39, 0) == 0);
            err_clr   = ($urandom_range(29, 0) == 0);
            if ($urandom_range(49, 0) == 0) auto_run = ~auto_run;
            if (n == 700) do_reset();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
